alu_ctrl_mem_unit: RTL and testbench
====================================

ALU_CTRL_MEM_UNIT -- requirements
Module: alu_ctrl_mem_unit

Interface
REQ-001 clk  input  1  sole clock; RAM writes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 op  input  6  instruction [31:26].
REQ-004 funct  input  6  instruction [5:0].
REQ-005 alu_x  input  32  first operand, already muxed by datapath.
REQ-006 alu_y  input  32  second operand; shift amount in [4:0] for shifts.
REQ-007 mem_din  input  32  store data (rt value).
REQ-008 aluop  output  4  decoded ALU operation.
REQ-009 ctrl  output  18  flags, bit 17..0: rf_dst, rf_we, branch, jump, mem_we, mem_to_reg, alu_src, shift, branch_eq, branch_leq, jump_reg, jal, usign, sys, shift_var, load_imm, store_half, exce_ret.
REQ-010 alu_r1 / alu_r2  output  32 each  primary / secondary result.
REQ-011 alu_eq / alu_leq  output  1 each  x==y; signed x<=y.
REQ-012 ram_dout  output  32  word read at alu_r1[11:2].

Function
REQ-013 aluop codes: 0 SLL, 1 SRA, 2 SRL, 3 MUL, 4 DIV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 XOR, 10 NOR, 11 SLT signed, 12 SLTU; 13-15 SHALL give r1=r2=0.
REQ-014 Shifts use alu_y[4:0] only; ADD/SUB wrap modulo 2^32, no overflow trap; SLT/SLTU give r1=0 or 1.
REQ-015 MUL: signed 64-bit product, r1=low word, r2=high word; DIV: signed, r1=quotient, r2=remainder; divide by zero gives r1=0, r2=alu_x; all other ops r2=0.
REQ-016 alu_eq and alu_leq valid for every aluop, combinational.
REQ-017 Decoder, op=0 by funct: 00 sll, 02 srl, 03 sra, 04 sllv, 06 srlv, 07 srav, 08 jr, 0C syscall, 20 add, 21 addu, 22 sub, 23 subu, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu.
REQ-018 Decoder by op: 02 j, 03 jal, 04 beq, 05 bne, 06 blez, 08 addi, 09 addiu, 0A slti, 0B sltiu, 0C andi, 0D ori, 0E xori, 0F lui, 23 lw, 29 sh, 2B sw; op=10 with funct=18 eret.
REQ-019 R-type ALU ops: rf_dst=rf_we=1; shifts add shift=1; sllv/srlv/srav add shift_var=1.
REQ-020 I-type ALU ops: alu_src=rf_we=1; andi/ori/xori add usign=1; lui: rf_we=load_imm=1.
REQ-021 lw: ADD, alu_src, mem_to_reg, rf_we; sw: ADD, alu_src, mem_we; sh: as sw plus store_half.
REQ-022 beq: branch, branch_eq, SUB; bne: branch, SUB; blez: branch, branch_leq.
REQ-023 j: jump; jal: jump, jal, rf_we; jr: jump_reg; syscall: sys; eret: exce_ret.
REQ-024 Unlisted op/funct: all ctrl=0, aluop=5; never writes RAM or regfile.
REQ-025 RAM: 1024x32, combinational read, write on rising clk when ctrl.mem_we=1 and rst=0.
REQ-026 store_half: write mem_din[15:0] into half selected by alu_r1[1] (0 = bits 15:0, 1 = bits 31:16); other half keeps old value.
REQ-027 Read of address being written returns old data until the edge, new data after.
REQ-028 Address bits [31:12] and [1:0] (except REQ-026) ignored; addresses wrap modulo 4 KiB.

Reset
REQ-029 rst=1 asynchronously clears all RAM words to 0 and blocks writes; ram_dout=0 immediately.
REQ-030 Decoder and ALU are combinational, unaffected by reset; no other state exists.

Verification
REQ-031 op=00 funct=20, x=7FFFFFFF, y=1 -> aluop=5, r1=80000000, rf_dst=rf_we=1, eq=0.
REQ-032 op=00 funct=03, x=80000000, y=4 -> aluop=1, r1=F8000000, shift=1; funct=02 -> r1=08000000.
REQ-033 op=2B, x=10, y=4 (r1=14), mem_din=DEADBEEF, clk edge -> ram_dout=DEADBEEF at word 5; then op=29, r1=16, mem_din=1234 -> word 5=1234BEEF.
REQ-034 op=06, x=FFFFFFFF, y=0 -> branch=branch_leq=1, alu_leq=1; x=1 -> alu_leq=0.
REQ-035 aluop DIV via forced decode path, x=-7, y=2 -> r1=FFFFFFFD, r2=FFFFFFFF; y=0 -> r1=0, r2=FFFFFFF9.
REQ-036 Write word 3, assert rst mid-cycle -> ram_dout=0 instantly; mem_we edge during rst leaves RAM 0.

Source files
------------

// File: rtl/alu_ctrl_mem_unit.sv
// alu_ctrl_mem_unit: instruction decoder, 32-bit ALU and a 1024x32 data RAM.
//
// Ports
//   clk       : clock, RAM writes on the rising edge
//   rst       : asynchronous active-high reset, clears every RAM word
//   op        : instruction bits [31:26]
//   funct     : instruction bits [5:0]
//   alu_x     : first ALU operand
//   alu_y     : second ALU operand (shift amount in [4:0] for shifts)
//   mem_din   : store data
//   aluop     : decoded ALU operation
//   ctrl      : control flags, bit 17..0 = rf_dst, rf_we, branch, jump, mem_we,
//               mem_to_reg, alu_src, shift, branch_eq, branch_leq, jump_reg,
//               jal, usign, sys, shift_var, load_imm, store_half, exce_ret
//   alu_r1    : primary ALU result (also the RAM byte address)
//   alu_r2    : secondary ALU result (MUL high word, DIV remainder)
//   alu_eq    : alu_x == alu_y
//   alu_leq   : signed alu_x <= alu_y
//   ram_dout  : word at alu_r1[11:2], combinational read
//
// There is no handshake: decode and ALU are purely combinational and a store
// commits on the rising edge whenever ctrl.mem_we is high and rst is low.

// ALU: combinational, selected by a 4-bit operation code.
module alu_ctrl_mem_alu (
  input  logic [3:0]  aluop,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] r1,
  output logic [31:0] r2,
  output logic        eq,
  output logic        leq
);

  logic signed [63:0] x_ext;
  logic signed [63:0] y_ext;
  logic signed [63:0] prod;
  logic signed [31:0] sx;
  logic signed [31:0] sy;
  logic signed [31:0] quo;
  logic signed [31:0] rem;
  logic               div_ovf;

  assign x_ext = {{32{x[31]}}, x};
  assign y_ext = {{32{y[31]}}, y};
  assign prod  = x_ext * y_ext;
  assign sx    = x;
  assign sy    = y;

  // -2^31 / -1 does not fit; give the wrapped quotient and a zero remainder.
  assign div_ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);

  always_comb begin
    quo = '0;
    rem = '0;
    if (y == 32'd0) begin
      quo = '0;
      rem = sx;
    end else if (div_ovf) begin
      quo = sx;
      rem = '0;
    end else begin
      quo = sx / sy;
      rem = sx % sy;
    end
  end

  assign eq  = (x == y);
  assign leq = (sx <= sy);

  always_comb begin
    r1 = '0;
    r2 = '0;
    case (aluop)
      4'd0:  r1 = x << y[4:0];
      4'd1:  r1 = $unsigned(sx >>> y[4:0]);
      4'd2:  r1 = x >> y[4:0];
      4'd3:  begin r1 = prod[31:0]; r2 = prod[63:32]; end
      4'd4:  begin r1 = quo; r2 = rem; end
      4'd5:  r1 = x + y;
      4'd6:  r1 = x - y;
      4'd7:  r1 = x & y;
      4'd8:  r1 = x | y;
      4'd9:  r1 = x ^ y;
      4'd10: r1 = ~(x | y);
      4'd11: r1 = {31'd0, (sx < sy)};
      4'd12: r1 = {31'd0, (x < y)};
      default: begin r1 = '0; r2 = '0; end
    endcase
  end

endmodule

module alu_ctrl_mem_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic [31:0] alu_x,
  input  logic [31:0] alu_y,
  input  logic [31:0] mem_din,
  output logic [3:0]  aluop,
  output logic [17:0] ctrl,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic        alu_eq,
  output logic        alu_leq,
  output logic [31:0] ram_dout
);

  localparam int B_RF_DST     = 17;
  localparam int B_RF_WE      = 16;
  localparam int B_BRANCH     = 15;
  localparam int B_JUMP       = 14;
  localparam int B_MEM_WE     = 13;
  localparam int B_MEM_TO_REG = 12;
  localparam int B_ALU_SRC    = 11;
  localparam int B_SHIFT      = 10;
  localparam int B_BRANCH_EQ  = 9;
  localparam int B_BRANCH_LEQ = 8;
  localparam int B_JUMP_REG   = 7;
  localparam int B_JAL        = 6;
  localparam int B_USIGN      = 5;
  localparam int B_SYS        = 4;
  localparam int B_SHIFT_VAR  = 3;
  localparam int B_LOAD_IMM   = 2;
  localparam int B_STORE_HALF = 1;
  localparam int B_EXCE_RET   = 0;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOR  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;

  // Decoder. Anything not recognised leaves every flag low and aluop=ADD,
  // so it can never write the RAM or the register file.
  always_comb begin
    ctrl  = '0;
    aluop = OP_ADD;
    case (op)
      6'h00: begin
        case (funct)
          6'h00: begin aluop = OP_SLL; ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; ctrl[B_SHIFT] = 1'b1; end
          6'h02: begin aluop = OP_SRL; ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; ctrl[B_SHIFT] = 1'b1; end
          6'h03: begin aluop = OP_SRA; ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; ctrl[B_SHIFT] = 1'b1; end
          6'h04: begin
            aluop = OP_SLL; ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1;
            ctrl[B_SHIFT] = 1'b1; ctrl[B_SHIFT_VAR] = 1'b1;
          end
          6'h06: begin
            aluop = OP_SRL; ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1;
            ctrl[B_SHIFT] = 1'b1; ctrl[B_SHIFT_VAR] = 1'b1;
          end
          6'h07: begin
            aluop = OP_SRA; ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1;
            ctrl[B_SHIFT] = 1'b1; ctrl[B_SHIFT_VAR] = 1'b1;
          end
          6'h08: ctrl[B_JUMP_REG] = 1'b1;
          6'h0C: ctrl[B_SYS] = 1'b1;
          6'h20, 6'h21: begin aluop = OP_ADD;  ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          6'h22, 6'h23: begin aluop = OP_SUB;  ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          6'h24:        begin aluop = OP_AND;  ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          6'h25:        begin aluop = OP_OR;   ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          6'h26:        begin aluop = OP_XOR;  ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          6'h27:        begin aluop = OP_NOR;  ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          6'h2A:        begin aluop = OP_SLT;  ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          6'h2B:        begin aluop = OP_SLTU; ctrl[B_RF_DST] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
          default: ;
        endcase
      end
      6'h02: ctrl[B_JUMP] = 1'b1;
      6'h03: begin ctrl[B_JUMP] = 1'b1; ctrl[B_JAL] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
      6'h04: begin aluop = OP_SUB; ctrl[B_BRANCH] = 1'b1; ctrl[B_BRANCH_EQ] = 1'b1; end
      6'h05: begin aluop = OP_SUB; ctrl[B_BRANCH] = 1'b1; end
      6'h06: begin ctrl[B_BRANCH] = 1'b1; ctrl[B_BRANCH_LEQ] = 1'b1; end
      6'h08, 6'h09: begin aluop = OP_ADD;  ctrl[B_ALU_SRC] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
      6'h0A:        begin aluop = OP_SLT;  ctrl[B_ALU_SRC] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
      6'h0B:        begin aluop = OP_SLTU; ctrl[B_ALU_SRC] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
      6'h0C: begin aluop = OP_AND; ctrl[B_ALU_SRC] = 1'b1; ctrl[B_RF_WE] = 1'b1; ctrl[B_USIGN] = 1'b1; end
      6'h0D: begin aluop = OP_OR;  ctrl[B_ALU_SRC] = 1'b1; ctrl[B_RF_WE] = 1'b1; ctrl[B_USIGN] = 1'b1; end
      6'h0E: begin aluop = OP_XOR; ctrl[B_ALU_SRC] = 1'b1; ctrl[B_RF_WE] = 1'b1; ctrl[B_USIGN] = 1'b1; end
      6'h0F: begin ctrl[B_RF_WE] = 1'b1; ctrl[B_LOAD_IMM] = 1'b1; end
      6'h23: begin aluop = OP_ADD; ctrl[B_ALU_SRC] = 1'b1; ctrl[B_MEM_TO_REG] = 1'b1; ctrl[B_RF_WE] = 1'b1; end
      6'h29: begin aluop = OP_ADD; ctrl[B_ALU_SRC] = 1'b1; ctrl[B_MEM_WE] = 1'b1; ctrl[B_STORE_HALF] = 1'b1; end
      6'h2B: begin aluop = OP_ADD; ctrl[B_ALU_SRC] = 1'b1; ctrl[B_MEM_WE] = 1'b1; end
      6'h10: if (funct == 6'h18) ctrl[B_EXCE_RET] = 1'b1;
      default: ;
    endcase
  end

  alu_ctrl_mem_alu u_alu (
    .aluop (aluop),
    .x     (alu_x),
    .y     (alu_y),
    .r1    (alu_r1),
    .r2    (alu_r2),
    .eq    (alu_eq),
    .leq   (alu_leq)
  );

  // Data RAM: word address from alu_r1[11:2], so addresses wrap every 4 KiB.
  logic [31:0] mem [1024];
  logic [9:0]  addr;
  logic [31:0] wr_word;

  assign addr = alu_r1[11:2];

  // Half-word stores merge into the current word; alu_r1[1] picks the half.
  always_comb begin
    wr_word = mem_din;
    if (ctrl[B_STORE_HALF]) begin
      if (alu_r1[1]) wr_word = {mem_din[15:0], mem[addr][15:0]};
      else           wr_word = {mem[addr][31:16], mem_din[15:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (ctrl[B_MEM_WE]) begin
      mem[addr] <= wr_word;
    end
  end

  // Reading straight from the array returns old data until the write edge.
  assign ram_dout = mem[addr];

endmodule

// File: tb/tb_alu_ctrl_mem_unit.sv
module tb_alu_ctrl_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [31:0] mem_din;
  logic [3:0]  aluop;
  logic [17:0] ctrl;
  logic [31:0] alu_r1;
  logic [31:0] alu_r2;
  logic        alu_eq;
  logic        alu_leq;
  logic [31:0] ram_dout;

  // standalone ALU instance so operation codes the decoder never emits
  // (MUL, DIV, 13-15) can be driven directly
  logic [3:0]  f_aluop;
  logic [31:0] f_x;
  logic [31:0] f_y;
  logic [31:0] f_r1;
  logic [31:0] f_r2;
  logic        f_eq;
  logic        f_leq;

  localparam logic [17:0] C_RF_DST     = 18'd1 << 17;
  localparam logic [17:0] C_RF_WE      = 18'd1 << 16;
  localparam logic [17:0] C_BRANCH     = 18'd1 << 15;
  localparam logic [17:0] C_JUMP       = 18'd1 << 14;
  localparam logic [17:0] C_MEM_WE     = 18'd1 << 13;
  localparam logic [17:0] C_MEM_TO_REG = 18'd1 << 12;
  localparam logic [17:0] C_ALU_SRC    = 18'd1 << 11;
  localparam logic [17:0] C_SHIFT      = 18'd1 << 10;
  localparam logic [17:0] C_BRANCH_EQ  = 18'd1 << 9;
  localparam logic [17:0] C_BRANCH_LEQ = 18'd1 << 8;
  localparam logic [17:0] C_JUMP_REG   = 18'd1 << 7;
  localparam logic [17:0] C_JAL        = 18'd1 << 6;
  localparam logic [17:0] C_USIGN      = 18'd1 << 5;
  localparam logic [17:0] C_SYS        = 18'd1 << 4;
  localparam logic [17:0] C_SHIFT_VAR  = 18'd1 << 3;
  localparam logic [17:0] C_LOAD_IMM   = 18'd1 << 2;
  localparam logic [17:0] C_STORE_HALF = 18'd1 << 1;
  localparam logic [17:0] C_EXCE_RET   = 18'd1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;
  logic [31:0] model_mem [1024];

  alu_ctrl_mem_unit dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .funct    (funct),
    .alu_x    (alu_x),
    .alu_y    (alu_y),
    .mem_din  (mem_din),
    .aluop    (aluop),
    .ctrl     (ctrl),
    .alu_r1   (alu_r1),
    .alu_r2   (alu_r2),
    .alu_eq   (alu_eq),
    .alu_leq  (alu_leq),
    .ram_dout (ram_dout)
  );

  alu_ctrl_mem_alu u_alu_direct (
    .aluop (f_aluop),
    .x     (f_x),
    .y     (f_y),
    .r1    (f_r1),
    .r2    (f_r2),
    .eq    (f_eq),
    .leq   (f_leq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver: change inputs on the falling edge, let combinational paths settle
  task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] d);
    @(negedge clk);
    op = o; funct = f; alu_x = x; alu_y = y; mem_din = d;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; op = 6'h2B; funct = 6'h00; alu_x = 32'h10; alu_y = 32'h4; mem_din = 32'hAAAA_5555;
    f_aluop = 4'd0; f_x = '0; f_y = '0;
    clear_model();
    #1;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL reset_dout: got %h expected %h", ram_dout, exp); end
    exp_q.push_back(32'd5);
    exp = exp_q.pop_front(); checks++;
    if ({28'd0, aluop} !== exp) begin errors++; $display("FAIL reset_decode_aluop: got %0d expected %0d", aluop, exp); end
    exp_q.push_back({14'd0, C_ALU_SRC | C_MEM_WE});
    exp = exp_q.pop_front(); checks++;
    if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL reset_decode_ctrl: got %h expected %h", ctrl, exp); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; op = 6'h23;
    #1;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL reset_write_blocked: got %h expected %h", ram_dout, exp); end
  endtask

  task automatic test_add();
    apply(6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1, 32'h0);
    exp_q.push_back(32'd5); exp_q.push_back(32'h8000_0000);
    exp_q.push_back({14'd0, C_RF_DST | C_RF_WE}); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if ({28'd0, aluop} !== exp) begin errors++; $display("FAIL add_aluop: got %0d expected %0d", aluop, exp); end
    exp = exp_q.pop_front(); checks++;
    if (alu_r1 !== exp) begin errors++; $display("FAIL add_r1: got %h expected %h", alu_r1, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL add_ctrl: got %h expected %h", ctrl, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, alu_eq} !== exp) begin errors++; $display("FAIL add_eq: got %b expected %0d", alu_eq, exp); end
    exp = exp_q.pop_front(); checks++;
    if (alu_r2 !== exp) begin errors++; $display("FAIL add_r2: got %h expected %h", alu_r2, exp); end
  endtask

  task automatic test_shift();
    logic [5:0]  f_tab [4] = '{6'h03, 6'h02, 6'h04, 6'h07};
    logic [31:0] x_tab [4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'hF000_0000};
    logic [31:0] y_tab [4] = '{32'h4, 32'h4, 32'hFFFF_FFE3, 32'h24};
    logic [31:0] r_tab [4] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0008, 32'hFF00_0000};
    logic [3:0]  a_tab [4] = '{4'd1, 4'd2, 4'd0, 4'd1};
    logic [17:0] c_tab [4];
    c_tab[0] = C_RF_DST | C_RF_WE | C_SHIFT;
    c_tab[1] = C_RF_DST | C_RF_WE | C_SHIFT;
    c_tab[2] = C_RF_DST | C_RF_WE | C_SHIFT | C_SHIFT_VAR;
    c_tab[3] = C_RF_DST | C_RF_WE | C_SHIFT | C_SHIFT_VAR;
    for (int i = 0; i < 4; i++) begin
      apply(6'h00, f_tab[i], x_tab[i], y_tab[i], 32'h0);
      exp_q.push_back({28'd0, a_tab[i]}); exp_q.push_back(r_tab[i]); exp_q.push_back({14'd0, c_tab[i]});
      exp = exp_q.pop_front(); checks++;
      if ({28'd0, aluop} !== exp) begin errors++; $display("FAIL shift%0d_aluop: got %0d expected %0d", i, aluop, exp); end
      exp = exp_q.pop_front(); checks++;
      if (alu_r1 !== exp) begin errors++; $display("FAIL shift%0d_r1: got %h expected %h", i, alu_r1, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL shift%0d_ctrl: got %h expected %h", i, ctrl, exp); end
    end
  endtask

  task automatic test_logic();
    logic [5:0]  f_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    for (int n = 0; n < 6; n++) begin
      x = $urandom();
      y = (n == 2) ? x : $urandom();
      if (n == 3) y = 32'h0000_0001;
      if (n == 3) x = 32'hFFFF_FFFF;
      for (int i = 0; i < 8; i++) begin
        apply(6'h00, f_tab[i], x, y, 32'h0);
        case (f_tab[i])
          6'h20:   r = x + y;
          6'h22:   r = x - y;
          6'h24:   r = x & y;
          6'h25:   r = x | y;
          6'h26:   r = x ^ y;
          6'h27:   r = ~(x | y);
          6'h2A:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          default: r = (x < y) ? 32'd1 : 32'd0;
        endcase
        exp_q.push_back(r);
        exp_q.push_back((x == y) ? 32'd1 : 32'd0);
        exp = exp_q.pop_front(); checks++;
        if (alu_r1 !== exp) begin errors++; $display("FAIL logic_f%h_r1: x=%h y=%h got %h expected %h", f_tab[i], x, y, alu_r1, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, alu_eq} !== exp) begin errors++; $display("FAIL logic_eq: got %b expected %0d", alu_eq, exp); end
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0]  o_tab [4] = '{6'h0C, 6'h0A, 6'h0F, 6'h0B};
    logic [3:0]  a_tab [4] = '{4'd7, 4'd11, 4'd5, 4'd12};
    logic [31:0] r_tab [4] = '{32'h0000_00F0, 32'h1, 32'h0000_0100, 32'h0};
    logic [17:0] c_tab [4];
    c_tab[0] = C_ALU_SRC | C_RF_WE | C_USIGN;
    c_tab[1] = C_ALU_SRC | C_RF_WE;
    c_tab[2] = C_RF_WE | C_LOAD_IMM;
    c_tab[3] = C_ALU_SRC | C_RF_WE;
    // x=FFFFFFF0 y=F0 for andi (F0), slti (-16 < 240 -> 1), sltiu (0)
    for (int i = 0; i < 4; i++) begin
      if (i == 2) apply(o_tab[i], 6'h00, 32'h0000_00F0, 32'h0000_0010, 32'h0);
      else        apply(o_tab[i], 6'h00, 32'hFFFF_FFF0, 32'h0000_00F0, 32'h0);
      exp_q.push_back({28'd0, a_tab[i]}); exp_q.push_back(r_tab[i]); exp_q.push_back({14'd0, c_tab[i]});
      exp = exp_q.pop_front(); checks++;
      if ({28'd0, aluop} !== exp) begin errors++; $display("FAIL itype%0d_aluop: got %0d expected %0d", i, aluop, exp); end
      exp = exp_q.pop_front(); checks++;
      if (alu_r1 !== exp) begin errors++; $display("FAIL itype%0d_r1: got %h expected %h", i, alu_r1, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL itype%0d_ctrl: got %h expected %h", i, ctrl, exp); end
    end
  endtask

  task automatic test_branch();
    apply(6'h06, 6'h00, 32'hFFFF_FFFF, 32'h0, 32'h0);
    exp_q.push_back({14'd0, C_BRANCH | C_BRANCH_LEQ}); exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL blez_ctrl: got %h expected %h", ctrl, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, alu_leq} !== exp) begin errors++; $display("FAIL blez_leq_neg: got %b expected %0d", alu_leq, exp); end
    apply(6'h06, 6'h00, 32'h1, 32'h0, 32'h0);
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, alu_leq} !== exp) begin errors++; $display("FAIL blez_leq_pos: got %b expected %0d", alu_leq, exp); end
    apply(6'h06, 6'h00, 32'h0, 32'h0, 32'h0);
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, alu_leq} !== exp) begin errors++; $display("FAIL blez_leq_zero: got %b expected %0d", alu_leq, exp); end
    apply(6'h04, 6'h00, 32'h55, 32'h55, 32'h0);
    exp_q.push_back({14'd0, C_BRANCH | C_BRANCH_EQ}); exp_q.push_back(32'd6); exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL beq_ctrl: got %h expected %h", ctrl, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({28'd0, aluop} !== exp) begin errors++; $display("FAIL beq_aluop: got %0d expected %0d", aluop, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, alu_eq} !== exp) begin errors++; $display("FAIL beq_eq: got %b expected %0d", alu_eq, exp); end
    apply(6'h05, 6'h00, 32'h3, 32'h5, 32'h0);
    exp_q.push_back({14'd0, C_BRANCH}); exp_q.push_back(32'hFFFF_FFFE); exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL bne_ctrl: got %h expected %h", ctrl, exp); end
    exp = exp_q.pop_front(); checks++;
    if (alu_r1 !== exp) begin errors++; $display("FAIL bne_r1: got %h expected %h", alu_r1, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, alu_eq} !== exp) begin errors++; $display("FAIL bne_eq: got %b expected %0d", alu_eq, exp); end
  endtask

  task automatic test_jump();
    logic [5:0]  o_tab [5] = '{6'h02, 6'h03, 6'h00, 6'h00, 6'h10};
    logic [5:0]  f_tab [5] = '{6'h00, 6'h00, 6'h08, 6'h0C, 6'h18};
    logic [17:0] c_tab [5];
    c_tab[0] = C_JUMP;
    c_tab[1] = C_JUMP | C_JAL | C_RF_WE;
    c_tab[2] = C_JUMP_REG;
    c_tab[3] = C_SYS;
    c_tab[4] = C_EXCE_RET;
    for (int i = 0; i < 5; i++) begin
      apply(o_tab[i], f_tab[i], $urandom(), $urandom(), 32'h0);
      exp_q.push_back({14'd0, c_tab[i]});
      exp = exp_q.pop_front(); checks++;
      if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL jump%0d_ctrl: got %h expected %h", i, ctrl, exp); end
    end
  endtask

  task automatic test_store();
    apply(6'h2B, 6'h00, 32'h10, 32'h4, 32'hDEAD_BEEF);
    exp_q.push_back(model_mem[5]);
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL sw_old_before_edge: got %h expected %h", ram_dout, exp); end
    model_mem[5] = 32'hDEAD_BEEF;
    exp_q.push_back(model_mem[5]);
    @(posedge clk); #1;
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL sw_word5: got %h expected %h", ram_dout, exp); end
    apply(6'h29, 6'h00, 32'h12, 32'h4, 32'h0000_1234);
    exp_q.push_back({14'd0, C_ALU_SRC | C_MEM_WE | C_STORE_HALF});
    exp = exp_q.pop_front(); checks++;
    if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL sh_ctrl: got %h expected %h", ctrl, exp); end
    model_mem[5] = {16'h1234, model_mem[5][15:0]};
    exp_q.push_back(model_mem[5]);
    @(posedge clk); #1;
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL sh_upper: got %h expected %h", ram_dout, exp); end
    apply(6'h29, 6'h00, 32'h14, 32'h0, 32'hFFFF_5678);
    model_mem[5] = {model_mem[5][31:16], 16'h5678};
    exp_q.push_back(model_mem[5]);
    @(posedge clk); #1;
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL sh_lower: got %h expected %h", ram_dout, exp); end
    // upper address bits ignored: 0x1017 still reads word 5
    apply(6'h23, 6'h00, 32'h1017, 32'h0, 32'h0);
    exp_q.push_back(model_mem[5]); exp_q.push_back({14'd0, C_ALU_SRC | C_MEM_TO_REG | C_RF_WE});
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL lw_wrap: got %h expected %h", ram_dout, exp); end
    exp = exp_q.pop_front(); checks++;
    if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL lw_ctrl: got %h expected %h", ctrl, exp); end
  endtask

  task automatic test_unlisted();
    logic [5:0] o_tab [3] = '{6'h3F, 6'h00, 6'h10};
    logic [5:0] f_tab [3] = '{6'h00, 6'h3F, 6'h00};
    for (int i = 0; i < 3; i++) begin
      apply(o_tab[i], f_tab[i], 32'h14, 32'h0, 32'h0BAD_0BAD);
      exp_q.push_back(32'd0); exp_q.push_back(32'd5);
      exp = exp_q.pop_front(); checks++;
      if ({14'd0, ctrl} !== exp) begin errors++; $display("FAIL unlisted%0d_ctrl: got %h expected %h", i, ctrl, exp); end
      exp = exp_q.pop_front(); checks++;
      if ({28'd0, aluop} !== exp) begin errors++; $display("FAIL unlisted%0d_aluop: got %0d expected %0d", i, aluop, exp); end
      exp_q.push_back(model_mem[5]);
      @(posedge clk); #1;
      exp = exp_q.pop_front(); checks++;
      if (ram_dout !== exp) begin errors++; $display("FAIL unlisted%0d_no_write: got %h expected %h", i, ram_dout, exp); end
    end
  endtask

  task automatic test_back_to_back();
    int          words[$];
    int          w;
    logic [31:0] d;
    for (int i = 0; i < 10; i++) begin
      w = (i == 3) ? words[0] : $urandom_range(0, 1023);
      d = $urandom();
      words.push_back(w);
      apply(6'h2B, 6'h00, ($urandom() & 32'hFFFF_F000) | (w << 2), 32'h0, d);
      model_mem[w] = d;
      @(posedge clk);
    end
    for (int i = 0; i < 10; i++) begin
      w = words.pop_front();
      apply(6'h23, 6'h00, w << 2, 32'h0, 32'h0);
      exp_q.push_back(model_mem[w]);
      exp = exp_q.pop_front(); checks++;
      if (ram_dout !== exp) begin errors++; $display("FAIL b2b_word%0d: got %h expected %h", w, ram_dout, exp); end
    end
  endtask

  task automatic test_alu_direct();
    logic [3:0]  a_tab  [8] = '{4'd4, 4'd4, 4'd4, 4'd3, 4'd3, 4'd13, 4'd14, 4'd15};
    logic [31:0] x_tab  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'hFFFF_FFFF, 32'h0001_0000,
                               32'h5, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] y_tab  [8] = '{32'h2, 32'h0, 32'd7, 32'h2, 32'h0001_0000, 32'h5, 32'h9, 32'h3};
    logic [31:0] r1_tab [8] = '{32'hFFFF_FFFD, 32'h0, 32'd14, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] r2_tab [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 8; i++) begin
      f_aluop = a_tab[i]; f_x = x_tab[i]; f_y = y_tab[i];
      exp_q.push_back(r1_tab[i]); exp_q.push_back(r2_tab[i]);
      #1;
      exp = exp_q.pop_front(); checks++;
      if (f_r1 !== exp) begin errors++; $display("FAIL alu_op%0d_r1: got %h expected %h", f_aluop, f_r1, exp); end
      exp = exp_q.pop_front(); checks++;
      if (f_r2 !== exp) begin errors++; $display("FAIL alu_op%0d_r2: got %h expected %h", f_aluop, f_r2, exp); end
    end
    exp_q.push_back(32'd1);
    exp = exp_q.pop_front(); checks++;
    if ({31'd0, f_leq} !== exp) begin errors++; $display("FAIL alu_leq_op15: got %b expected %0d", f_leq, exp); end
  endtask

  task automatic test_reset_mid();
    apply(6'h2B, 6'h00, 32'hC, 32'h0, 32'hCAFE_F00D);
    model_mem[3] = 32'hCAFE_F00D;
    exp_q.push_back(model_mem[3]);
    @(posedge clk); #1;
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL mid_word3: got %h expected %h", ram_dout, exp); end
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL mid_async_clear: got %h expected %h", ram_dout, exp); end
    @(posedge clk); #1;
    exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL mid_write_blocked: got %h expected %h", ram_dout, exp); end
    @(negedge clk);
    rst = 1'b0; op = 6'h23; alu_x = 32'h14;
    #1;
    exp_q.push_back(model_mem[5]);
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL mid_word5_cleared: got %h expected %h", ram_dout, exp); end
    apply(6'h23, 6'h00, 32'hC, 32'h0, 32'h0);
    exp_q.push_back(model_mem[3]);
    exp = exp_q.pop_front(); checks++;
    if (ram_dout !== exp) begin errors++; $display("FAIL mid_word3_cleared: got %h expected %h", ram_dout, exp); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_logic();
    test_itype();
    test_branch();
    test_jump();
    test_store();
    test_unlisted();
    test_back_to_back();
    test_alu_direct();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
